// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, synchronizes the rows,
// debounces press and release over DEBOUNCE_SCANS scan ticks, and reports one key at a time.
module keypad_scanner #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_tick,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_e;

  localparam logic [3:0] CNT_LIMIT = 4'(DEBOUNCE_SCANS);

  state_e     state_q, state_d;
  logic [3:0] sync1_q, rows_s_q;
  logic [1:0] col_q, col_d;
  logic [1:0] cand_row_q, cand_row_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0] key_code_q, key_code_d;
  logic [3:0] col_out_q;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;
  logic [1:0] low_row;
  logic       any_low;
  logic       same_row;

  assign any_low  = (rows_s_q != 4'b1111);
  assign cnt_inc  = cnt_q + 4'd1;
  assign same_row = any_low && (low_row == cand_row_q);

  // Lowest-indexed low row wins when several rows are pulled down together.
  always_comb begin
    low_row = 2'd3;
    if      (!rows_s_q[0]) low_row = 2'd0;
    else if (!rows_s_q[1]) low_row = 2'd1;
    else if (!rows_s_q[2]) low_row = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SCAN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (scan_tick) begin
      case (state_q)
        SCAN:     if (any_low) state_d = DEBOUNCE;
        DEBOUNCE: begin
          if (!same_row)                  state_d = SCAN;
          else if (cnt_inc == CNT_LIMIT)  state_d = PRESSED;
        end
        PRESSED:  if (!any_low && cnt_inc == CNT_LIMIT) state_d = SCAN;
        default:  state_d = SCAN;
      endcase
    end
  end

  always_comb begin
    col_d       = col_q;
    cand_row_d  = cand_row_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (scan_tick) begin
      case (state_q)
        SCAN: begin
          if (any_low) begin
            cand_row_d = low_row;
            cnt_d      = 4'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!same_row) begin
            cnt_d = '0;
            col_d = col_q + 2'd1;
          end else if (cnt_inc == CNT_LIMIT) begin
            cnt_d       = '0;
            key_code_d  = {col_q, cand_row_q};
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        PRESSED: begin
          // Any low row (including a second key) restarts the release count.
          if (any_low) begin
            cnt_d = '0;
          end else if (cnt_inc == CNT_LIMIT) begin
            cnt_d      = '0;
            key_held_d = 1'b0;
            col_d      = col_q + 2'd1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '1;
      rows_s_q    <= '1;
      col_q       <= '0;
      col_out_q   <= 4'b1110;
      cand_row_q  <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      sync1_q     <= row_in;
      rows_s_q    <= sync1_q;
      col_q       <= col_d;
      col_out_q   <= ~(4'b0001 << col_d);
      cand_row_q  <= cand_row_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_out   = col_out_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule
